// File: rtl/chain_score_reduce.sv
// Per-anchor chain score reduction: f[i] = max(w_i, max_j(f[j] + score(j,i))) with best predecessor.
// Optional early termination of a group after MAX_SKIP non-improving candidates: define CHAIN_MAX_SKIP_EN.
module chain_score_reduce #(
  parameter int SCORE_W  = 32,
  parameter int IDX_W    = 16,
  parameter int MAX_SKIP = 25
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_first,
  input  logic               in_last,
  input  logic               in_pred_valid,
  input  logic [SCORE_W-1:0] in_wi,
  input  logic [SCORE_W-1:0] in_score,
  input  logic [SCORE_W-1:0] in_fj,
  input  logic [IDX_W-1:0]   in_j,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SCORE_W-1:0] out_f,
  output logic [IDX_W-1:0]   out_p,
  output logic [IDX_W-1:0]   out_anchor,
  output logic               err
);

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

  localparam logic [IDX_W-1:0] NO_PRED = '1;

  state_t                    state, state_nx;
  logic signed [SCORE_W-1:0] best_f, base_f, upd_f, cand;
  logic signed [SCORE_W:0]   sum;
  logic [IDX_W-1:0]          best_p, base_p, upd_p;
  logic [IDX_W-1:0]          anchor;
  logic                      accept, take, proto_err, eval;

`ifdef CHAIN_MAX_SKIP_EN
  localparam int CNT_W = $clog2(MAX_SKIP + 1) + 1;
  logic [CNT_W-1:0] skip_cnt, base_cnt, upd_cnt;
`endif

  assign accept    = in_valid & in_ready;
  // A beat with in_first always (re)starts a group, even when it aborts an open one.
  assign take      = accept & (in_first | (state == ACCUM));
  assign proto_err = accept & (((state == IDLE) & ~in_first) | ((state == ACCUM) & in_first));

  // Saturating f[j] + score at SCORE_W+1 bits.
  always_comb begin
    sum = $signed({in_fj[SCORE_W-1], in_fj}) + $signed({in_score[SCORE_W-1], in_score});
    if (sum[SCORE_W] != sum[SCORE_W-1])
      cand = sum[SCORE_W] ? $signed({1'b1, {(SCORE_W-1){1'b0}}})
                          : $signed({1'b0, {(SCORE_W-1){1'b1}}});
    else
      cand = sum[SCORE_W-1:0];
  end

  always_comb begin
    base_f = in_first ? $signed(in_wi) : best_f;
    base_p = in_first ? NO_PRED : best_p;
    upd_f  = base_f;
    upd_p  = base_p;
`ifdef CHAIN_MAX_SKIP_EN
    base_cnt = in_first ? '0 : skip_cnt;
    upd_cnt  = base_cnt;
    eval     = in_pred_valid & (base_cnt < CNT_W'(MAX_SKIP));
`else
    eval     = in_pred_valid;
`endif
    if (eval) begin
      if (cand > base_f) begin
        upd_f = cand;
        upd_p = in_j;
`ifdef CHAIN_MAX_SKIP_EN
        upd_cnt = '0;
      end else begin
        upd_cnt = base_cnt + CNT_W'(1);
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, ACCUM: if (take) state_nx = in_last ? EMIT : ACCUM;
      EMIT:        if (out_ready) state_nx = IDLE;
      default:     state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state != EMIT);
    out_valid = (state == EMIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      best_f <= '0;
      best_p <= NO_PRED;
      anchor <= '0;
      err    <= 1'b0;
`ifdef CHAIN_MAX_SKIP_EN
      skip_cnt <= '0;
`endif
    end else begin
      if (take) begin
        best_f <= upd_f;
        best_p <= upd_p;
`ifdef CHAIN_MAX_SKIP_EN
        skip_cnt <= upd_cnt;
`endif
      end
      if (proto_err) err <= 1'b1;
      if ((state == EMIT) && out_ready) anchor <= anchor + IDX_W'(1);
    end
  end

  assign out_f      = best_f;
  assign out_p      = best_p;
  assign out_anchor = anchor;

endmodule

// File: tb/tb_chain_score_reduce.sv
// Directed bench for chain_score_reduce; a narrow-index second instance covers anchor wrap.
module tb_chain_score_reduce;

  localparam logic [15:0] NP = 16'hFFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_first, in_last, in_pred_valid, out_ready;
  logic [31:0] in_wi, in_score, in_fj;
  logic [15:0] in_j;
  logic        in_ready, out_valid, err;
  logic [31:0] out_f;
  logic [15:0] out_p, out_anchor;
  logic        s_in_ready, s_out_valid, s_err;
  logic [31:0] s_out_f;
  logic [3:0]  s_out_p, s_out_anchor;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  chain_score_reduce #(.SCORE_W(32), .IDX_W(16), .MAX_SKIP(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last), .in_pred_valid(in_pred_valid),
    .in_wi(in_wi), .in_score(in_score), .in_fj(in_fj), .in_j(in_j),
    .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f), .out_p(out_p),
    .out_anchor(out_anchor), .err(err)
  );

  chain_score_reduce #(.SCORE_W(32), .IDX_W(4), .MAX_SKIP(2)) dut_small (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_first(in_first), .in_last(in_last), .in_pred_valid(in_pred_valid),
    .in_wi(in_wi), .in_score(in_score), .in_fj(in_fj), .in_j(in_j[3:0]),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_f(s_out_f), .out_p(s_out_p),
    .out_anchor(s_out_anchor), .err(s_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic first, input logic last, input logic pv,
                      input logic [31:0] wi, input logic [31:0] fj,
                      input logic [31:0] score, input logic [15:0] j);
    in_valid = 1'b1; in_first = first; in_last = last; in_pred_valid = pv;
    in_wi = wi; in_fj = fj; in_score = score; in_j = j;
    @(posedge clk); #1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_pred_valid = 1'b0;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [31:0] f,
                               input logic [15:0] p, input logic [15:0] a);
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".f"}, 64'(out_f), 64'(f));
    check({tag, ".p"}, 64'(out_p), 64'(p));
    check({tag, ".anchor"}, 64'(out_anchor), 64'(a));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    in_pred_valid = 1'b0; out_ready = 1'b0;
    in_wi = '0; in_fj = '0; in_score = '0; in_j = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    check("rst.valid", 64'(out_valid), 64'd0);
    check("rst.f", 64'(out_f), 64'd0);
    check("rst.p", 64'(out_p), 64'(NP));
    check("rst.anchor", 64'(out_anchor), 64'd0);
    check("rst.err", 64'(err), 64'd0);
    check("rst.ready", 64'(in_ready), 64'd1);

    // Single-beat anchor, then backpressure for 5 cycles.
    beat(1'b1, 1'b1, 1'b0, 32'd15, 32'd0, 32'd0, 16'd0);
    expect_result("single", 32'd15, NP, 16'd0);
    for (int c = 0; c < 5; c++) begin
      check("hold.ready", 64'(in_ready), 64'd0);
      check("hold.f", 64'(out_f), 64'd15);
      check("hold.valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
    end
    take_result();
    check("xfer.valid", 64'(out_valid), 64'd0);
    check("xfer.anchor", 64'(out_anchor), 64'd1);

    // 50 -> j3, 55 -> j7, tie 55 keeps j7.
    beat(1'b1, 1'b0, 1'b1, 32'd15, 32'd40, 32'd10, 16'd3);
    beat(1'b0, 1'b0, 1'b1, 32'd0, 32'd60, -32'sd5, 16'd7);
    beat(1'b0, 1'b1, 1'b1, 32'd0, 32'd50, 32'd5, 16'd9);
    expect_result("group", 32'd55, 16'd7, 16'd1);
    take_result();

    // Positive saturation.
    beat(1'b1, 1'b1, 1'b1, 32'd1, 32'h7FFF_FFF0, 32'h20, 16'd4);
    expect_result("sat", 32'h7FFF_FFFF, 16'd4, 16'd2);
    take_result();

    // Negative saturation must not wrap into a large positive value.
    beat(1'b1, 1'b1, 1'b1, -32'sd5, 32'h8000_0000, -32'sd1, 16'd6);
    expect_result("negsat", -32'sd5, NP, 16'd3);
    take_result();

    // All candidates at or below w_i = 100; the last one ties w_i.
    beat(1'b1, 1'b0, 1'b1, 32'd100, 32'd50, 32'd10, 16'd1);
    beat(1'b0, 1'b0, 1'b1, 32'd0, -32'sd200, 32'd250, 16'd2);
    beat(1'b0, 1'b1, 1'b1, 32'd0, 32'd90, 32'd10, 16'd5);
    expect_result("below", 32'd100, NP, 16'd4);
    take_result();

    // Candidates 5, 5, 50 against w_i = 10 with MAX_SKIP = 2.
    beat(1'b1, 1'b0, 1'b1, 32'd10, 32'd5, 32'd0, 16'd1);
    beat(1'b0, 1'b0, 1'b1, 32'd0, 32'd5, 32'd0, 16'd2);
    beat(1'b0, 1'b1, 1'b1, 32'd0, 32'd50, 32'd0, 16'd3);
`ifdef CHAIN_MAX_SKIP_EN
    expect_result("skip", 32'd10, NP, 16'd5);
`else
    expect_result("skip", 32'd50, 16'd3, 16'd5);
`endif
    take_result();
    check("pre.err", 64'(err), 64'd0);

    // Stray beat in IDLE is dropped and flags err.
    beat(1'b0, 1'b1, 1'b1, 32'd0, 32'd500, 32'd0, 16'd8);
    check("stray.err", 64'(err), 64'd1);
    check("stray.valid", 64'(out_valid), 64'd0);
    check("stray.ready", 64'(in_ready), 64'd1);

    // in_first mid-group discards the open group.
    beat(1'b1, 1'b0, 1'b1, 32'd20, 32'd30, 32'd0, 16'd5);
    beat(1'b1, 1'b1, 1'b0, 32'd7, 32'd0, 32'd0, 16'd0);
    expect_result("restart", 32'd7, NP, 16'd6);
    check("restart.err", 64'(err), 64'd1);
    take_result();

    // Asynchronous reset in the middle of a group.
    beat(1'b1, 1'b0, 1'b1, 32'd99, 32'd200, 32'd0, 16'd2);
    #2 reset = 1'b1;
    #1;
    check("arst.valid", 64'(out_valid), 64'd0);
    check("arst.f", 64'(out_f), 64'd0);
    check("arst.p", 64'(out_p), 64'(NP));
    check("arst.anchor", 64'(out_anchor), 64'd0);
    check("arst.err", 64'(err), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("arst.novalid", 64'(out_valid), 64'd0);

    // 16 anchors: the 4-bit instance wraps 15 -> 0, the 16-bit one reaches 16.
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      beat(1'b1, 1'b1, 1'b0, 32'(k), 32'd0, 32'd0, 16'd0);
      check("burst.f", 64'(out_f), 64'(k));
      check("burst.anchor", 64'(out_anchor), 64'(k));
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    check("wrap.small", 64'(s_out_anchor), 64'd0);
    check("wrap.big", 64'(out_anchor), 64'd16);
    check("wrap.valid", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
